// File: rtl/user_voice_writer.sv
// User-instrument register writer: turns OPLL writes to $00-$07 into read-modify-write
// updates of voice 0 (modulator) and voice 1 (carrier) in the voice memory.
module user_voice_writer #(
  parameter int INIT_CYCLES = 128,
  parameter int VOICE_ID_W  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_reg_wr,
  input  logic [7:0]            i_reg_addr,
  input  logic [7:0]            i_reg_data,
  output logic                  o_reg_ready,
  output logic [VOICE_ID_W-1:0] o_vm_addr,
  output logic                  o_vm_wr,
  output logic [35:0]           o_vm_wdata,
  input  logic [35:0]           i_vm_rdata,
  output logic                  o_busy
);

  // Voice word layout, MSB first: AM PM EG KR ML[4] | KL[2] TL[6] | WF FB[3] | AR[4] DR[4] | SL[4] RR[4]
  localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_MRG, S_WB} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]      r_addr;
  logic [7:0]      r_data;
  logic            r_pass2;
  logic            w_accept;
  logic            w_user_reg;
  logic            w_slot;
  logic            w_init_done;
  logic [35:0]     w_merged;

  assign w_accept    = (r_state == S_IDLE) && i_reg_wr;
  assign w_user_reg  = (i_reg_addr <= 8'h07);
  assign w_slot      = i_reg_addr[0] && (i_reg_addr[2:0] != 3'd3);
  assign w_init_done = (r_cnt == CNT_W'(INIT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_INIT;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_reg_ready = 1'b0;
    case (r_state)
      S_INIT: if (w_init_done) w_next = S_IDLE;
      S_IDLE: begin
        o_reg_ready = 1'b1;
        if (w_accept && w_user_reg) w_next = S_RD;
      end
      S_RD:   w_next = S_MRG;
      S_MRG:  w_next = S_WB;
      S_WB:   w_next = (r_addr == 3'd3 && !r_pass2) ? S_RD : S_IDLE;
      default: w_next = S_INIT;
    endcase
  end

  assign o_busy = !o_reg_ready;

  // $03 is split: pass 1 touches the modulator, pass 2 the carrier.
  always_comb begin
    w_merged = i_vm_rdata;
    case (r_addr)
      3'd0, 3'd1: w_merged[35:28] = r_data;
      3'd2:       w_merged[27:20] = r_data;
      3'd3: begin
        if (!r_pass2) begin
          w_merged[19:16] = r_data[3:0];
        end else begin
          w_merged[27:26] = r_data[7:6];
          w_merged[19]    = r_data[4];
        end
      end
      3'd4, 3'd5: w_merged[15:8] = r_data;
      default:    w_merged[7:0]  = r_data;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_pass2    <= 1'b0;
      o_vm_addr  <= '0;
      o_vm_wr    <= 1'b0;
      o_vm_wdata <= '0;
    end else begin
      o_vm_wr <= (r_state == S_MRG);
      case (r_state)
        S_INIT: if (!w_init_done) r_cnt <= r_cnt + 1'b1;
        S_IDLE: begin
          if (w_accept && w_user_reg) begin
            r_addr    <= i_reg_addr[2:0];
            r_data    <= i_reg_data;
            r_pass2   <= 1'b0;
            o_vm_addr <= {{(VOICE_ID_W-1){1'b0}}, w_slot};
          end
        end
        S_MRG: o_vm_wdata <= w_merged;
        S_WB: begin
          if (r_addr == 3'd3 && !r_pass2) begin
            r_pass2   <= 1'b1;
            o_vm_addr <= {{(VOICE_ID_W-1){1'b0}}, 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_user_voice_writer.sv
// Self-checking bench for user_voice_writer: registered voice-memory model plus a
// field-level reference model of the user-instrument register map.
module tb_user_voice_writer;

  localparam int INIT_CYCLES = 128;

  logic        clk = 1'b0;
  logic        rstN;
  logic        regWr;
  logic [7:0]  regAddr;
  logic [7:0]  regData;
  logic        regReady;
  logic        busy;
  logic [4:0]  vmAddr;
  logic        vmWr;
  logic [35:0] vmWdata;
  logic [35:0] vmRdata;

  logic [35:0] mem [0:31];
  logic        tbWr;
  logic [4:0]  tbAddr;
  logic [35:0] tbData;

  int errorCount = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  user_voice_writer #(.INIT_CYCLES(INIT_CYCLES), .VOICE_ID_W(5)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_reg_wr   (regWr),
    .i_reg_addr (regAddr),
    .i_reg_data (regData),
    .o_reg_ready(regReady),
    .o_vm_addr  (vmAddr),
    .o_vm_wr    (vmWr),
    .o_vm_wdata (vmWdata),
    .i_vm_rdata (vmRdata),
    .o_busy     (busy)
  );

  // Voice memory: registered read port, write at the end of a vm_wr cycle.
  always @(posedge clk) begin
    if (vmWr) mem[vmAddr] <= vmWdata;
    else if (tbWr) mem[tbAddr] <= tbData;
    vmRdata <= mem[vmAddr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [35:0] putField(input logic [35:0] v, input int lsb, input int width, input int val);
    logic [35:0] mask;
    mask = ((36'd1 << width) - 36'd1) << lsb;
    return (v & ~mask) | ((36'(val) << lsb) & mask);
  endfunction

  // Expected voice word after one register pass, field by field.
  function automatic logic [35:0] refVoice(input logic [35:0] old, input logic [7:0] a,
                                           input logic [7:0] d, input bit pass2);
    logic [35:0] v;
    int di;
    v  = old;
    di = int'(d);
    case (a)
      8'h00, 8'h01: begin
        v = putField(v, 35, 1, (di >> 7) & 1);
        v = putField(v, 34, 1, (di >> 6) & 1);
        v = putField(v, 33, 1, (di >> 5) & 1);
        v = putField(v, 32, 1, (di >> 4) & 1);
        v = putField(v, 28, 4, di % 16);
      end
      8'h02: begin
        v = putField(v, 26, 2, di / 64);
        v = putField(v, 20, 6, di % 64);
      end
      8'h03: begin
        if (!pass2) begin
          v = putField(v, 19, 1, (di >> 3) & 1);
          v = putField(v, 16, 3, di % 8);
        end else begin
          v = putField(v, 26, 2, di / 64);
          v = putField(v, 19, 1, (di >> 4) & 1);
        end
      end
      8'h04, 8'h05: begin
        v = putField(v, 12, 4, di / 16);
        v = putField(v, 8, 4, di % 16);
      end
      8'h06, 8'h07: begin
        v = putField(v, 4, 4, di / 16);
        v = putField(v, 0, 4, di % 16);
      end
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [35:0] rand36();
    return {4'($urandom), 32'($urandom)};
  endfunction

  task automatic presetMem(input logic [35:0] v0, input logic [35:0] v1);
    tbWr = 1'b1; tbAddr = 5'd0; tbData = v0;
    @(posedge clk); #1;
    tbAddr = 5'd1; tbData = v1;
    @(posedge clk); #1;
    tbWr = 1'b0;
  endtask

  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (regReady) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic countInit(input string tag);
    int n;
    n = 0;
    while (!regReady && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, n, INIT_CYCLES);
  endtask

  // One register write; tracks vm_wr pulses and when reg_ready returns, in edges after accept.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input bit changeData, input string tag);
    bit          ok;
    int          pulses;
    int          readyEdge;
    int          expSlot;
    int          expPulses;
    int          expReady;
    logic [35:0] expWord;
    pulses    = 0;
    readyEdge = -1;
    waitReady(ok);
    checkOutput({tag, " ready before accept"}, ok, 1);
    regWr = 1'b1; regAddr = a; regData = d;
    @(posedge clk); #1;
    regWr = 1'b0;
    if (changeData) begin
      regData = 8'h00;
      regAddr = 8'hFF;
    end
    for (int j = 0; j < 10; j++) begin
      if (vmWr) begin
        expSlot = (pulses == 0) ? ((a == 8'h03) ? 0 : int'(a[0])) : 1;
        expWord = refVoice(mem[expSlot], a, d, pulses == 1);
        checkOutput({tag, " pulse edge"}, j + 1, (pulses == 0) ? 3 : 6);
        checkOutput({tag, " vm_addr"}, vmAddr, expSlot);
        checkOutput({tag, " vm_wdata"}, vmWdata, expWord);
        pulses++;
      end
      if (regReady && readyEdge < 0) readyEdge = j + 1;
      @(posedge clk); #1;
    end
    expPulses = (a > 8'h07) ? 0 : ((a == 8'h03) ? 2 : 1);
    expReady  = (a > 8'h07) ? 1 : ((a == 8'h03) ? 7 : 4);
    checkOutput({tag, " pulse count"}, pulses, expPulses);
    checkOutput({tag, " ready edge"}, readyEdge, expReady);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          ok;
    int          wrCount;
    logic [35:0] saved;
    logic [7:0]  a;
    rstN = 1'b0; regWr = 1'b0; regAddr = 8'h00; regData = 8'h00;
    tbWr = 1'b0; tbAddr = 5'd0; tbData = '0;
    repeat (2) @(posedge clk);
    #1;
    presetMem(rand36(), rand36());

    checkOutput("reset reg_ready", regReady, 0);
    checkOutput("reset busy", busy, 1);
    checkOutput("reset vm_wr", vmWr, 0);
    checkOutput("reset vm_addr", vmAddr, 0);
    checkOutput("reset vm_wdata", vmWdata, 0);

    regWr = 1'b1; regAddr = 8'h00; regData = 8'hE1;
    @(negedge clk) rstN = 1'b1;
    countInit("startup init cycles");
    applyStimulus(8'h00, 8'hE1, 1'b0, "w00_E1");

    presetMem({36{1'b1}}, {36{1'b1}});
    applyStimulus(8'h05, 8'hA3, 1'b0, "w05_A3");
    checkOutput("w05_A3 mem1", mem[1], 36'hFFFFFA3FF);

    presetMem('0, '0);
    applyStimulus(8'h03, 8'hDF, 1'b0, "w03_DF");
    checkOutput("w03_DF mem0", mem[0], 36'h0000F0000);
    checkOutput("w03_DF mem1", mem[1], 36'h00C080000);

    waitReady(ok);
    regWr = 1'b1; regAddr = 8'h08; regData = 8'hFF;
    @(posedge clk); #1;
    checkOutput("b2b ready after 08", regReady, 1);
    regAddr = 8'h2A; regData = 8'h00;
    @(posedge clk); #1;
    regWr = 1'b0;
    wrCount = 0;
    for (int j = 0; j < 6; j++) begin
      if (vmWr) wrCount++;
      @(posedge clk); #1;
    end
    checkOutput("b2b vm_wr count", wrCount, 0);
    checkOutput("b2b ready after 2A", regReady, 1);

    presetMem(rand36(), rand36());
    applyStimulus(8'h02, 8'h7F, 1'b1, "w02_latched");
    checkOutput("w02_latched KL/TL", mem[0][27:20], 8'h7F);

    presetMem(rand36(), rand36());
    saved = mem[0];
    waitReady(ok);
    regWr = 1'b1; regAddr = 8'h06; regData = 8'h5A;
    @(posedge clk); #1;
    regWr = 1'b0;
    ok = 1'b0;
    for (int j = 0; j < 6 && !ok; j++) begin
      if (vmWr) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput("midreset reached WB", ok, 1);
    rstN = 1'b0;
    #1;
    checkOutput("midreset vm_wr", vmWr, 0);
    checkOutput("midreset reg_ready", regReady, 0);
    checkOutput("midreset vm_wdata", vmWdata, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    countInit("midreset init cycles");
    checkOutput("midreset mem0 untouched", mem[0], saved);

    for (int k = 0; k < 40; k++) begin
      presetMem(rand36(), rand36());
      a = 8'($urandom_range(0, 11));
      applyStimulus(a, 8'($urandom), 1'($urandom), $sformatf("rand%0d_a%0h", k, a));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
